// File: rtl/wb_serial_master.sv
// rtl/wb_serial_master.sv - byte-stream command frames to single 32-bit Wishbone cycles
module wb_serial_master #(
    parameter int bus_timeout   = 1024,
    parameter int frame_timeout = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy
);
    localparam logic [2:0] st_idle = 3'd0;
    localparam logic [2:0] st_addr = 3'd1;
    localparam logic [2:0] st_data = 3'd2;
    localparam logic [2:0] st_bus  = 3'd3;
    localparam logic [2:0] st_resp = 3'd4;

    localparam int bw = (bus_timeout > 1) ? $clog2(bus_timeout) : 1;
    localparam int fw = (frame_timeout > 1) ? $clog2(frame_timeout) : 1;

    localparam logic [7:0] ch_w = 8'h57;
    localparam logic [7:0] ch_r = 8'h52;
    localparam logic [7:0] ch_k = 8'h4B;
    localparam logic [7:0] ch_e = 8'h45;

    logic [2:0]    state, state_next;
    logic          we;
    logic [1:0]    byte_cnt;
    logic [31:0]   addr, wdata, resp_shift;
    logic [1:0]    resp_left;
    logic [bw-1:0] bus_cnt;
    logic [fw-1:0] frame_cnt;
    logic          term, bus_timeout_hit, frame_timeout_hit, tx_fire;

    assign term              = wb_ack_i | wb_err_i | wb_rty_i;
    assign bus_timeout_hit   = (bus_cnt == bw'(bus_timeout - 1));
    assign frame_timeout_hit = !rx_valid && (frame_cnt == fw'(frame_timeout - 1));
    assign tx_fire           = tx_valid & tx_ready;
    assign wb_sel_o          = 4'hF;

    always_comb begin
        state_next = state;
        case (state)
            st_idle: if (rx_valid && (rx_data == ch_w || rx_data == ch_r)) state_next = st_addr;
            st_addr: begin
                if (rx_valid && byte_cnt == 2'd3) state_next = we ? st_data : st_bus;
                else if (frame_timeout_hit)       state_next = st_idle;
            end
            st_data: begin
                if (rx_valid && byte_cnt == 2'd3) state_next = st_bus;
                else if (frame_timeout_hit)       state_next = st_idle;
            end
            st_bus:  if (term || bus_timeout_hit) state_next = st_resp;
            st_resp: if (tx_fire && resp_left == 2'd0) state_next = st_idle;
            default: state_next = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= st_idle;
            busy       <= 1'b0;
            we         <= 1'b0;
            byte_cnt   <= 2'd0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            resp_shift <= 32'd0;
            resp_left  <= 2'd0;
            bus_cnt    <= '0;
            frame_cnt  <= '0;
            wb_adr_o   <= 32'd0;
            wb_dat_o   <= 32'd0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != st_idle);
            case (state)
                st_idle: begin
                    byte_cnt  <= 2'd0;
                    frame_cnt <= '0;
                    if (state_next == st_addr) we <= (rx_data == ch_w);
                end
                st_addr, st_data: begin
                    if (rx_valid) begin
                        byte_cnt  <= byte_cnt + 2'd1;
                        frame_cnt <= '0;
                        if (state == st_addr) addr  <= {addr[23:0], rx_data};
                        else                  wdata <= {wdata[23:0], rx_data};
                        // The final byte is still on rx_data, so the bus fields are assembled from it directly.
                        if (state_next == st_bus) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= we;
                            bus_cnt  <= '0;
                            if (state == st_addr) begin
                                wb_adr_o <= {addr[23:0], rx_data[7:2], 2'b00};
                                wb_dat_o <= wdata;
                            end else begin
                                wb_adr_o <= {addr[31:2], 2'b00};
                                wb_dat_o <= {wdata[23:0], rx_data};
                            end
                        end
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                st_bus: begin
                    bus_cnt <= bus_cnt + 1'b1;
                    if (term || bus_timeout_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        tx_valid <= 1'b1;
                        if (wb_ack_i && !we) begin
                            tx_data    <= wb_dat_i[31:24];
                            resp_shift <= {wb_dat_i[23:0], 8'd0};
                            resp_left  <= 2'd3;
                        end else begin
                            tx_data   <= wb_ack_i ? ch_k : ch_e;
                            resp_left <= 2'd0;
                        end
                    end
                end
                st_resp: begin
                    if (tx_fire) begin
                        if (resp_left == 2'd0) begin
                            tx_valid <= 1'b0;
                        end else begin
                            tx_data    <= resp_shift[31:24];
                            resp_shift <= {resp_shift[23:0], 8'd0};
                            resp_left  <= resp_left - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_serial_master.sv
// tb/tb_wb_serial_master.sv - frame-level model and scoreboard bench for wb_serial_master
module tb_wb_serial_master;
    localparam int M_ACK = 0, M_ERR = 1, M_RTY = 2, M_NONE = 3, M_ACKERR = 4;
    localparam int FT = 40;

    logic        clk, reset;
    logic [7:0]  rx_data, tx_data;
    logic        rx_valid, tx_valid, tx_ready;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i, busy;

    wb_serial_master #(.bus_timeout(16), .frame_timeout(FT)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .busy(busy)
    );

    int checks = 0, failures = 0;
    int edge_n = 0, rx_assert_edge = 0, cyc_rise_edge = 0, cyc_fall_edge = 0, tx_rise_edge = 0;
    int n_bus = 0, n_tx = 0;
    int slv_mode = M_ACK, slv_delay = 0, slv_wait = 0;
    bit throttle = 0;
    logic [31:0] slv_rdata = 0, obs_adr = 0, obs_dat = 0;
    logic        obs_we = 0;
    logic [7:0]  last_tx = 0;

    logic [31:0] exp_adr[$], exp_dat[$];
    logic        exp_we[$];
    logic [7:0]  exp_tx[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); edge_n++; end

    initial begin
        int tcnt = 0;
        tx_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (throttle) begin tcnt++; tx_ready = (tcnt % 3 == 0); end
            else tx_ready = 1;
        end
    end

    // Slave: terminates slv_delay cycles after it first sees stb, in the chosen manner.
    initial begin
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = 0;
        forever begin
            @(negedge clk);
            wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
            if (wb_cyc_o && wb_stb_o && !reset) begin
                if (slv_wait == slv_delay) begin
                    wb_dat_i = slv_rdata;
                    case (slv_mode)
                        M_ACK:    wb_ack_i = 1;
                        M_ERR:    wb_err_i = 1;
                        M_RTY:    wb_rty_i = 1;
                        M_ACKERR: begin wb_ack_i = 1; wb_err_i = 1; end
                        default:  ;
                    endcase
                end
                slv_wait++;
            end else slv_wait = 0;
        end
    end

    // Scoreboard: every bus cycle and every accepted byte is matched against the model queues.
    initial begin
        bit prev_cyc = 0, prev_hold = 0, prev_txv = 0;
        logic [7:0] held = 0, e;
        forever begin
            @(negedge clk);
            if (reset) begin prev_cyc = 0; prev_hold = 0; prev_txv = 0; continue; end
            if (wb_cyc_o && !prev_cyc) begin
                n_bus++;
                cyc_rise_edge = edge_n;
                obs_adr = wb_adr_o; obs_we = wb_we_o; obs_dat = wb_dat_o;
                check("stb_with_cyc", wb_stb_o, 1);
                check("sel", wb_sel_o, 4'hF);
                check("pending_txn", exp_adr.size() > 0, 1);
                if (exp_adr.size() > 0) begin
                    logic [31:0] ea, ed;
                    logic ew;
                    ea = exp_adr.pop_front(); ew = exp_we.pop_front(); ed = exp_dat.pop_front();
                    check("adr", wb_adr_o, ea);
                    check("we", wb_we_o, ew);
                    if (ew) check("dat_o", wb_dat_o, ed);
                end
            end else if (wb_cyc_o) begin
                check("adr_stable", wb_adr_o, obs_adr);
                check("we_stable", wb_we_o, obs_we);
                check("dat_stable", wb_dat_o, obs_dat);
                check("stb_stable", wb_stb_o, 1);
            end
            if (!wb_cyc_o && prev_cyc) cyc_fall_edge = edge_n;
            prev_cyc = wb_cyc_o;
            if (tx_valid && !prev_txv) tx_rise_edge = edge_n;
            if (prev_hold) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_data", tx_data, held);
            end
            if (tx_valid && tx_ready) begin
                check("pending_tx", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    check("tx_byte", tx_data, e);
                end
                n_tx++;
                last_tx = tx_data;
            end
            prev_hold = tx_valid && !tx_ready;
            held = tx_data;
            prev_txv = tx_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1; rx_assert_edge = edge_n;
        @(posedge clk); #1;
        rx_valid = 0;
    endtask

    task automatic do_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int mode, input int dly, input logic [31:0] rd);
        slv_mode = mode; slv_delay = dly; slv_rdata = rd;
        exp_adr.push_back({a[31:2], 2'b00}); exp_we.push_back(w); exp_dat.push_back(d);
        if (mode == M_ACK || mode == M_ACKERR) begin
            if (w) exp_tx.push_back(8'h4B);
            else for (int i = 0; i < 4; i++) exp_tx.push_back(rd[31-8*i -: 8]);
        end else exp_tx.push_back(8'h45);
        send_byte(w ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
        if (w) for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || exp_tx.size() != 0) && n < 400);
        check({nm, "_done"}, busy || exp_tx.size() != 0, 0);
        check({nm, "_txn_seen"}, exp_adr.size(), 0);
    endtask

    initial begin
        int nb, nt, n;
        reset = 1; rx_valid = 0; rx_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", wb_cyc_o, 0);   check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);     check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);   check("rst_sel", wb_sel_o, 4'hF);
        check("rst_txv", tx_valid, 0);   check("rst_txd", tx_data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1; reset = 0;

        // 1: write to GPIO, slave acks two cycles after stb
        nb = n_bus; nt = n_tx;
        do_cmd(1, 32'hE0040000, 32'h000000A5, M_ACK, 2, 0);
        wait_done("gpio_write");
        check("gpio_one_cycle", n_bus - nb, 1);
        check("gpio_adr_lit", obs_adr, 32'hE0040000);
        check("gpio_dat_lit", obs_dat, 32'h000000A5);
        check("gpio_we_lit", obs_we, 1);
        check("gpio_resp_cnt", n_tx - nt, 1);
        check("gpio_resp_lit", last_tx, 8'h4B);

        // 2: read from BRAM with unaligned address and throttled transmitter
        throttle = 1; nt = n_tx;
        do_cmd(0, 32'h00000103, 0, M_ACK, 0, 32'hDEADBEEF);
        wait_done("bram_read");
        throttle = 0;
        check("bram_adr_lit", obs_adr, 32'h00000100);
        check("bram_we_lit", obs_we, 0);
        check("bram_resp_cnt", n_tx - nt, 4);
        check("bram_last_lit", last_tx, 8'hEF);

        // 3A/3A': err and rty both answer 'E'
        do_cmd(1, 32'h10000004, 32'h11223344, M_ERR, 1, 0);
        wait_done("err");
        check("err_resp_lit", last_tx, 8'h45);
        do_cmd(0, 32'h10000008, 0, M_RTY, 0, 32'h55AA55AA);
        wait_done("rty");
        check("rty_resp_lit", last_tx, 8'h45);

        // 3B: no termination, aborted after 16 cycles
        do_cmd(0, 32'h20000000, 0, M_NONE, 0, 0);
        wait_done("timeout");
        check("timeout_len", cyc_fall_edge - cyc_rise_edge, 16);
        check("timeout_resp_lit", last_tx, 8'h45);

        // 3C: ack together with err is an OK read
        do_cmd(0, 32'h30000010, 0, M_ACKERR, 0, 32'h12345678);
        wait_done("ack_err");
        check("ack_err_last_lit", last_tx, 8'h78);

        // turnaround with ack one cycle after stb and ready tied high
        do_cmd(1, 32'h00000040, 32'hCAFEF00D, M_ACK, 1, 0);
        wait_done("turnaround");
        check("cyc_rise_latency", cyc_rise_edge - rx_assert_edge, 1);
        check("turnaround", tx_rise_edge - rx_assert_edge, 3);

        // 4: garbage before a valid read
        nb = n_bus;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h41);
        @(negedge clk);
        check("garbage_idle", busy, 0);
        do_cmd(0, 32'hE0000000, 0, M_ACK, 0, 32'h0BADF00D);
        wait_done("resync_read");
        check("resync_one_cycle", n_bus - nb, 1);
        check("resync_adr_lit", obs_adr, 32'hE0000000);

        // partial frame then frame-timeout gap
        nb = n_bus;
        send_byte(8'h57); send_byte(8'hE0);
        repeat (FT - 1) @(posedge clk);
        @(negedge clk);
        check("frame_gap_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("frame_gap_idle", busy, 0);
        check("partial_no_bus", n_bus - nb, 0);
        do_cmd(1, 32'h40000000, 32'h00000001, M_ACK, 0, 0);
        wait_done("after_partial");
        check("after_partial_cycles", n_bus - nb, 1);

        // 5: reset while cyc is high
        do_cmd(0, 32'h50000000, 0, M_NONE, 0, 0);
        n = 0;
        while (!wb_cyc_o && n < 50) begin @(negedge clk); n++; end
        check("cyc_before_reset", wb_cyc_o, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cyc", wb_cyc_o, 0);
        check("mid_rst_stb", wb_stb_o, 0);
        check("mid_rst_txv", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        #1 reset = 0;
        exp_tx.delete();
        repeat (20) @(negedge clk);
        check("post_rst_no_resp", tx_valid, 0);

        // bytes arriving during RESP are dropped
        throttle = 1;
        do_cmd(0, 32'h60000000, 0, M_ACK, 0, 32'hA1B2C3D4);
        n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        check("resp_started", tx_valid, 1);
        nb = n_bus;
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        wait_done("drop");
        throttle = 0;
        repeat (FT + 5) @(negedge clk);
        check("drop_no_bus", n_bus - nb, 0);
        check("drop_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
